// File: rtl/lvds_frame_aligner_pkg.sv
// Shared types and width helpers for the LVDS frame aligner.
// Counter widths are derived from the alignment limits with $clog2.
package lvds_frame_aligner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_VERIFY,
        ST_LOCKED
    } state_e;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    // slip_count must hold 0..DW.
    function automatic int unsigned slip_width(input int unsigned dw);
        return $clog2(dw) + 1;
    endfunction

    localparam int unsigned DEF_N_LANES       = 2;
    localparam int unsigned DEF_DW            = 8;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;
    localparam int unsigned DEF_LOCK_COUNT    = 16;
    localparam int unsigned DEF_LOSS_COUNT    = 4;

    localparam int unsigned SETTLE_CNT_W = cnt_width(DEF_SETTLE_CYCLES);
    localparam int unsigned MATCH_CNT_W  = cnt_width(DEF_LOCK_COUNT);
    localparam int unsigned LOSS_CNT_W   = cnt_width(DEF_LOSS_COUNT);
    localparam int unsigned SLIP_CNT_W   = slip_width(DEF_DW);

endpackage

// File: rtl/lvds_frame_aligner_if.sv
// Control/data bundle between the deserialiser side and the frame aligner.
// master drives the lane words and controls; slave is the aligner.
interface lvds_frame_aligner_if #(
    parameter int unsigned N_LANES = 2,
    parameter int unsigned DW      = 8
);
    localparam int unsigned SW = lvds_frame_aligner_pkg::slip_width(DW);

    logic                    enable;
    logic                    realign;
    logic [DW-1:0]           frame_word;
    logic [N_LANES*DW-1:0]   data_in;
    logic                    bitslip;
    logic [N_LANES*DW-1:0]   data_out;
    logic                    data_valid;
    logic                    locked;
    logic [SW-1:0]           slip_count;
    logic                    error;

    modport master (
        output enable, realign, frame_word, data_in,
        input  bitslip, data_out, data_valid, locked, slip_count, error
    );

    modport slave (
        input  enable, realign, frame_word, data_in,
        output bitslip, data_out, data_valid, locked, slip_count, error
    );

endinterface

// File: rtl/lvds_frame_aligner_align_counter.sv
// Saturating, synchronously clearable up-counter used for settle/match/loss timing.
// term_o flags the count one below LIMIT, i.e. the next increment reaches it.
module align_counter
    import lvds_frame_aligner_pkg::*;
#(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = cnt_width(LIMIT)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != W'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term_o = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/lvds_frame_aligner.sv
// Frame-lane word aligner: hunts with ISERDES bitslip pulses until the frame
// lane shows FRAME_PATTERN, verifies it, then holds lock and gates data_valid.
module lvds_frame_aligner
    import lvds_frame_aligner_pkg::*;
#(
    parameter int unsigned N_LANES       = 2,
    parameter int unsigned DW            = 8,
    parameter logic [DW-1:0] FRAME_PATTERN = 8'hF0,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned LOSS_COUNT    = 4
) (
    input  logic                  sample_clk,
    input  logic                  reset_n,
    lvds_frame_aligner_if.slave   bus
);

    localparam int unsigned SW = slip_width(DW);

    state_e                  state_q;
    logic                    bitslip_q;
    logic                    data_valid_q;
    logic                    locked_q;
    logic                    error_q;
    logic [SW-1:0]           slip_count_q;
    logic [N_LANES*DW-1:0]   data_out_q;

    logic frame_match;
    logic hunt_abort;
    logic slip_wrap;
    logic settle_term, match_term, loss_term;
    logic settle_clr, match_clr, loss_clr;

    assign frame_match = (bus.frame_word == FRAME_PATTERN);
    assign hunt_abort  = !bus.enable || (bus.realign && (state_q != ST_IDLE));
    assign slip_wrap   = (slip_count_q == SW'(DW - 1));

    // Match counter stays at zero in CHECK, so a CHECK match loads it with 1.
    assign settle_clr = hunt_abort || (state_q != ST_SETTLE);
    assign match_clr  = hunt_abort || !frame_match ||
                        !((state_q == ST_CHECK) || (state_q == ST_VERIFY));
    assign loss_clr   = hunt_abort || frame_match || (state_q != ST_LOCKED);

    align_counter #(.LIMIT(SETTLE_CYCLES)) u_settle_cnt (
        .clk_i  (sample_clk),
        .rst_ni (reset_n),
        .clr_i  (settle_clr),
        .inc_i  (1'b1),
        .term_o (settle_term)
    );

    align_counter #(.LIMIT(LOCK_COUNT)) u_match_cnt (
        .clk_i  (sample_clk),
        .rst_ni (reset_n),
        .clr_i  (match_clr),
        .inc_i  (1'b1),
        .term_o (match_term)
    );

    align_counter #(.LIMIT(LOSS_COUNT)) u_loss_cnt (
        .clk_i  (sample_clk),
        .rst_ni (reset_n),
        .clr_i  (loss_clr),
        .inc_i  (1'b1),
        .term_o (loss_term)
    );

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bitslip_q    <= 1'b0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            slip_count_q <= '0;
            data_out_q   <= '0;
        end else begin
            data_out_q   <= bus.data_in;
            bitslip_q    <= 1'b0;
            data_valid_q <= 1'b0;
            if (!bus.enable) begin
                state_q      <= ST_IDLE;
                locked_q     <= 1'b0;
                slip_count_q <= '0;
            end else if (bus.realign && (state_q != ST_IDLE)) begin
                state_q      <= ST_CHECK;
                locked_q     <= 1'b0;
                slip_count_q <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_CHECK;
                        error_q      <= 1'b0;
                        slip_count_q <= '0;
                    end
                    // CHECK and VERIFY differ only in the match count carried in.
                    ST_CHECK, ST_VERIFY: begin
                        if (frame_match) begin
                            if (match_term) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q <= ST_VERIFY;
                            end
                        end else begin
                            state_q   <= ST_SLIP;
                            bitslip_q <= 1'b1;
                            if (slip_wrap) begin
                                slip_count_q <= '0;
                                error_q      <= 1'b1;
                            end else begin
                                slip_count_q <= slip_count_q + 1'b1;
                            end
                        end
                    end
                    ST_SLIP: begin
                        state_q <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_term) begin
                            state_q <= ST_CHECK;
                        end
                    end
                    ST_LOCKED: begin
                        if (!frame_match && loss_term) begin
                            state_q      <= ST_CHECK;
                            locked_q     <= 1'b0;
                            slip_count_q <= '0;
                        end else begin
                            data_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.bitslip    = bitslip_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.locked     = locked_q;
    assign bus.slip_count = slip_count_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_lvds_frame_aligner.sv
// Directed bench for lvds_frame_aligner: a rotating frame-lane model reacts
// to bitslip, and each scenario task checks hand-derived timing and flags.
module tb_lvds_frame_aligner;

    localparam int unsigned NL = 2;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int model_slips = 0;
    int rot_off = 0;
    bit use_fixed = 1'b0;
    logic [7:0]  fixed_word = 8'h00;
    logic [15:0] prev_din = '0;

    lvds_frame_aligner_if #(.N_LANES(NL), .DW(DW)) bus ();

    lvds_frame_aligner #(
        .N_LANES       (NL),
        .DW            (DW),
        .FRAME_PATTERN (8'hF0),
        .SETTLE_CYCLES (4),
        .LOCK_COUNT    (16),
        .LOSS_COUNT    (4)
    ) dut (
        .sample_clk (clk),
        .reset_n    (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int a);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < a; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic drive_frame();
        int amt;
        if (use_fixed) begin
            bus.frame_word = fixed_word;
        end else begin
            amt = ((rot_off - model_slips) % 8 + 8) % 8;
            bus.frame_word = rotl8(8'hF0, amt);
        end
    endtask

    // One clock: sample 1 time unit after the edge, then apply new stimulus.
    task automatic tick();
        @(posedge clk);
        #1;
        prev_din = bus.data_in;
        if (bus.bitslip === 1'b1) model_slips++;
        bus.data_in = 16'($urandom);
        drive_frame();
    endtask

    task automatic hunt(input int bound, output int nslips, output int first_slip,
                        output int last_slip, output int min_gap, output int max_gap,
                        output int t_lock, output int dout_bad);
        nslips = 0; first_slip = -1; last_slip = -1;
        min_gap = 1000; max_gap = 0; t_lock = -1; dout_bad = 0;
        for (int t = 1; t <= bound; t++) begin
            tick();
            if (bus.data_out !== prev_din) dout_bad++;
            if (bus.bitslip === 1'b1) begin
                if (last_slip >= 0) begin
                    if (t - last_slip < min_gap) min_gap = t - last_slip;
                    if (t - last_slip > max_gap) max_gap = t - last_slip;
                end else begin
                    first_slip = t;
                end
                last_slip = t;
                nslips++;
            end
            if (bus.locked === 1'b1) begin
                t_lock = t;
                break;
            end
        end
    endtask

    task automatic go_idle();
        bus.enable = 1'b0;
        bus.realign = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.realign = 1'b0;
        bus.data_in = 16'hA55A; use_fixed = 1'b0; rot_off = 0; model_slips = 0;
        drive_frame();
        tick(); tick();
        checks++; if (bus.bitslip !== 1'b0) begin errors++; $display("FAIL rst_bitslip got %b want 0", bus.bitslip); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b want 0", bus.locked); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.data_valid); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", bus.error); end
        checks++; if (bus.slip_count !== 4'd0) begin errors++; $display("FAIL rst_slipcnt got %0d want 0", bus.slip_count); end
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL rst_dout got %h want 0000", bus.data_out); end
        #3 rst_n = 1'b1;
        tick();
        checks++; if (bus.bitslip !== 1'b0 || bus.locked !== 1'b0) begin errors++; $display("FAIL idle_after_rst bitslip=%b locked=%b want 0 0", bus.bitslip, bus.locked); end
    endtask

    task automatic test_aligned();
        int ns, fs, ls, mn, mx, tl, db;
        go_idle();
        use_fixed = 1'b0; rot_off = 0; model_slips = 0;
        drive_frame();
        bus.enable = 1'b1;
        hunt(60, ns, fs, ls, mn, mx, tl, db);
        checks++; if (tl !== 17) begin errors++; $display("FAIL aligned_lock_time got %0d want 17", tl); end
        checks++; if (ns !== 0) begin errors++; $display("FAIL aligned_slips got %0d want 0", ns); end
        checks++; if (bus.slip_count !== 4'd0) begin errors++; $display("FAIL aligned_slipcnt got %0d want 0", bus.slip_count); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL aligned_first_valid got %b want 0", bus.data_valid); end
        checks++; if (db !== 0) begin errors++; $display("FAIL aligned_dout_hunt bad=%0d want 0", db); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL aligned_valid[%0d] got %b want 1", i, bus.data_valid); end
            checks++; if (bus.data_out !== prev_din) begin errors++; $display("FAIL aligned_dout[%0d] got %h want %h", i, bus.data_out, prev_din); end
        end
    endtask

    task automatic test_loss();
        use_fixed = 1'b1; fixed_word = 8'h00; drive_frame();
        tick(); tick(); tick();
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL loss_3miss locked=%b want 1", bus.locked); end
        fixed_word = 8'hF0; drive_frame();
        tick();
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL loss_match locked=%b want 1", bus.locked); end
        fixed_word = 8'h00; drive_frame();
        tick(); tick(); tick();
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL loss_3miss_again locked=%b want 1", bus.locked); end
        tick();
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL loss_4miss locked=%b want 0", bus.locked); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL loss_valid got %b want 0", bus.data_valid); end
        checks++; if (bus.slip_count !== 4'd0) begin errors++; $display("FAIL loss_slipcnt got %0d want 0", bus.slip_count); end
        tick();
        checks++; if (bus.bitslip !== 1'b1) begin errors++; $display("FAIL loss_rehunt bitslip=%b want 1", bus.bitslip); end
        checks++; if (bus.slip_count !== 4'd1) begin errors++; $display("FAIL loss_rehunt_cnt got %0d want 1", bus.slip_count); end
    endtask

    task automatic test_rotated();
        int ns, fs, ls, mn, mx, tl, db;
        go_idle();
        use_fixed = 1'b0; rot_off = 3; model_slips = 0;
        drive_frame();
        bus.enable = 1'b1;
        hunt(100, ns, fs, ls, mn, mx, tl, db);
        checks++; if (ns !== 3) begin errors++; $display("FAIL rot_slips got %0d want 3", ns); end
        checks++; if (fs !== 2) begin errors++; $display("FAIL rot_first_slip got %0d want 2", fs); end
        checks++; if (mn !== 6 || mx !== 6) begin errors++; $display("FAIL rot_gap got min %0d max %0d want 6 6", mn, mx); end
        checks++; if (tl - ls !== 21) begin errors++; $display("FAIL rot_lock_delay got %0d want 21", tl - ls); end
        checks++; if (bus.slip_count !== 4'd3) begin errors++; $display("FAIL rot_slipcnt got %0d want 3", bus.slip_count); end
        checks++; if (db !== 0) begin errors++; $display("FAIL rot_dout bad=%0d want 0", db); end
    endtask

    task automatic test_error();
        int n;
        bit done;
        go_idle();
        use_fixed = 1'b1; fixed_word = 8'h00; drive_frame();
        bus.enable = 1'b1;
        n = 0; done = 1'b0;
        for (int t = 1; t <= 120 && !done; t++) begin
            tick();
            if (bus.bitslip === 1'b1) begin
                n++;
                if (n == 7) begin
                    checks++; if (bus.error !== 1'b0 || bus.slip_count !== 4'd7) begin errors++; $display("FAIL err_slip7 error=%b cnt=%0d want 0 7", bus.error, bus.slip_count); end
                end else if (n == 8) begin
                    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", bus.error); end
                    checks++; if (bus.slip_count !== 4'd0) begin errors++; $display("FAIL err_wrap got %0d want 0", bus.slip_count); end
                end else if (n == 9) begin
                    checks++; if (bus.slip_count !== 4'd1 || bus.error !== 1'b1) begin errors++; $display("FAIL err_continue cnt=%0d error=%b want 1 1", bus.slip_count, bus.error); end
                    done = 1'b1;
                end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL err_timeout slips=%0d want 9", n); end
        bus.realign = 1'b1; tick(); bus.realign = 1'b0;
        checks++; if (bus.error !== 1'b1 || bus.slip_count !== 4'd0) begin errors++; $display("FAIL err_realign error=%b cnt=%0d want 1 0", bus.error, bus.slip_count); end
        bus.enable = 1'b0; tick();
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL err_idle_hold got %b want 1", bus.error); end
        bus.enable = 1'b1; tick();
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", bus.error); end
    endtask

    task automatic test_realign();
        int ns, fs, ls, mn, mx, tl, db;
        go_idle();
        use_fixed = 1'b0; rot_off = 0; model_slips = 0; drive_frame();
        bus.enable = 1'b1;
        hunt(60, ns, fs, ls, mn, mx, tl, db);
        checks++; if (tl !== 17) begin errors++; $display("FAIL realign_prelock got %0d want 17", tl); end
        tick();
        bus.realign = 1'b1; tick(); bus.realign = 1'b0;
        checks++; if (bus.locked !== 1'b0 || bus.data_valid !== 1'b0) begin errors++; $display("FAIL realign_drop locked=%b valid=%b want 0 0", bus.locked, bus.data_valid); end
        hunt(60, ns, fs, ls, mn, mx, tl, db);
        checks++; if (tl !== 16 || ns !== 0) begin errors++; $display("FAIL realign_relock t=%0d slips=%0d want 16 0", tl, ns); end
        bus.realign = 1'b1; bus.enable = 1'b0; tick();
        bus.realign = 1'b0;
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL realign_idle_drop locked=%b want 0", bus.locked); end
        bus.enable = 1'b1;
        hunt(60, ns, fs, ls, mn, mx, tl, db);
        checks++; if (tl !== 17) begin errors++; $display("FAIL realign_idle_wins t=%0d want 17", tl); end
    endtask

    task automatic test_async_reset();
        int ns, fs, ls, mn, mx, tl, db;
        bit seen;
        go_idle();
        use_fixed = 1'b0; rot_off = 3; model_slips = 0; drive_frame();
        bus.enable = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (bus.bitslip === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL ar_first_slip timeout"); end
        tick(); tick();
        checks++; if (bus.slip_count !== 4'd1) begin errors++; $display("FAIL ar_pre_cnt got %0d want 1", bus.slip_count); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.slip_count !== 4'd0 || bus.bitslip !== 1'b0 || bus.locked !== 1'b0) begin errors++; $display("FAIL ar_immediate cnt=%0d bitslip=%b locked=%b want 0 0 0", bus.slip_count, bus.bitslip, bus.locked); end
        checks++; if (bus.data_out !== 16'h0000 || bus.error !== 1'b0 || bus.data_valid !== 1'b0) begin errors++; $display("FAIL ar_immediate2 dout=%h error=%b valid=%b want 0000 0 0", bus.data_out, bus.error, bus.data_valid); end
        model_slips = 0; drive_frame();
        tick();
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL ar_hold dout=%h want 0000", bus.data_out); end
        #3 rst_n = 1'b1;
        hunt(100, ns, fs, ls, mn, mx, tl, db);
        checks++; if (fs !== 2 || ns !== 3) begin errors++; $display("FAIL ar_rehunt first=%0d slips=%0d want 2 3", fs, ns); end
        checks++; if (mn !== 6 || mx !== 6) begin errors++; $display("FAIL ar_gap got min %0d max %0d want 6 6", mn, mx); end
        checks++; if (tl - ls !== 21 || bus.slip_count !== 4'd3) begin errors++; $display("FAIL ar_lock delay=%0d cnt=%0d want 21 3", tl - ls, bus.slip_count); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_loss();
        test_rotated();
        test_error();
        test_realign();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
